// File: rtl/tone_seq.sv
// rtl/tone_seq.sv - square-wave tone sequencer with per-note duration and optional inter-note gap
//
// Plays one note at a time. A note has a half-period in clk cycles and a length in
// duration ticks. It is accepted through a valid/ready handshake.
//
// Optional feature macro: TONE_SEQ_GAP_EN
//   defined   : every note is followed by GAP_TICKS ticks of silence (GAP state)
//   undefined : PLAY returns straight to IDLE, and no gap logic is built
//
// Parameters
//   CNT_W     width of the half-period count
//   DUR_W     width of the note duration in ticks
//   TICK_DIV  clk cycles per duration tick
//   GAP_TICKS silence ticks after each note (used only with TONE_SEQ_GAP_EN)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   note_valid in   producer offers a note
//   note_ready out  high only in IDLE; accept = note_valid & note_ready
//   note_half  in   half-period in clk cycles, 0 = rest
//   note_dur   in   note length in ticks, 0 = a single PLAY cycle
//   sclk       out  registered square-wave tone
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse in the first IDLE cycle after a note

module tone_seq #(
    parameter int CNT_W     = 17,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [CNT_W-1:0] note_half,
    input  logic [DUR_W-1:0] note_dur,
    output logic             sclk,
    output logic             busy,
    output logic             done
);

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

`ifdef TONE_SEQ_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int               GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    logic [GAP_W-1:0] gap_q, gap_d;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [DUR_W-1:0]  dlen_q, dlen_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              sclk_q, sclk_d;
    logic              done_q, done_d;

    logic tick_wrap;
    logic play_last;

    assign tick_wrap = (tick_q == TICK_LAST);
    // Zero duration ends after the first PLAY cycle; otherwise end on the final tick
    // wrap. The subtraction is only used when dlen_q is non-zero.
    assign play_last = (dlen_q == '0) ||
                       (tick_wrap && (dur_q == (dlen_q - DUR_W'(1))));

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        dlen_d  = dlen_q;
        div_d   = div_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
`ifdef TONE_SEQ_GAP_EN
        gap_d   = gap_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (note_valid) begin
                    half_d  = note_half;
                    dlen_d  = note_dur;
                    div_d   = '0;
                    tick_d  = '0;
                    dur_d   = '0;
                    sclk_d  = 1'b0;
`ifdef TONE_SEQ_GAP_EN
                    gap_d   = '0;
`endif
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (play_last) begin
                    // Tone is silenced on the same edge that leaves PLAY.
                    sclk_d = 1'b0;
                    div_d  = '0;
                    tick_d = '0;
                    dur_d  = '0;
`ifdef TONE_SEQ_GAP_EN
                    if (GAP_TICKS == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        dur_d  = dur_q + DUR_W'(1);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    // A rest (half = 0) leaves the divider and tone idle.
                    if (half_q != '0) begin
                        if (div_q == (half_q - CNT_W'(1))) begin
                            div_d  = '0;
                            sclk_d = ~sclk_q;
                        end else begin
                            div_d = div_q + CNT_W'(1);
                        end
                    end
                end
            end

`ifdef TONE_SEQ_GAP_EN
            ST_GAP: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            half_q  <= '0;
            dlen_q  <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            dlen_q  <= dlen_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
`ifdef TONE_SEQ_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign note_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign sclk       = sclk_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tone_seq.sv
// tb/tb_tone_seq.sv - directed self-checking bench for tone_seq (default and 4-bit divider instances)

module tb_tone_seq;

    localparam int TDIV = 10;
    localparam int GAPT = 2;
`ifdef TONE_SEQ_GAP_EN
    localparam int GAP_CYC = GAPT * TDIV;
`else
    localparam int GAP_CYC = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        valid;
    logic [16:0] half;
    logic [15:0] dur;

    logic v1, v2;
    logic rdy1, sclk1, busy1, done1;
    logic rdy2, sclk2, busy2, done2;
    logic rdy_o, sclk_o, busy_o, done_o;

    int tests;
    int fails;

    assign v1 = valid & ~sel;
    assign v2 = valid & sel;

    assign rdy_o  = sel ? rdy2  : rdy1;
    assign sclk_o = sel ? sclk2 : sclk1;
    assign busy_o = sel ? busy2 : busy1;
    assign done_o = sel ? done2 : done1;

    tone_seq #(
        .CNT_W(17), .DUR_W(16), .TICK_DIV(TDIV), .GAP_TICKS(GAPT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .note_valid(v1), .note_ready(rdy1),
        .note_half(half), .note_dur(dur),
        .sclk(sclk1), .busy(busy1), .done(done1)
    );

    tone_seq #(
        .CNT_W(4), .DUR_W(16), .TICK_DIV(TDIV), .GAP_TICKS(GAPT)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .note_valid(v2), .note_ready(rdy2),
        .note_half(half[3:0]), .note_dur(dur),
        .sclk(sclk2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // Starts at a negedge with the selected DUT idle. Offers note (h,d); after the
    // accepting edge drives (nh,nd) and keeps valid at 'keep'. Checks every cycle of
    // PLAY and GAP, then the DONE cycle, and with keep=0 the cycle after it.
    task automatic play_note(input int h, input int d, input logic keep,
                             input int nh, input int nd, input string tag);
        int p;
        int e;
        p = (d == 0) ? 1 : d * TDIV;
        valid = 1'b1;
        half  = 17'(h);
        dur   = 16'(d);
        chk(tag, "ready_at_offer", 32'(rdy_o), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= p + GAP_CYC; c++) begin
            @(negedge clk);
            if (c == 1) begin
                valid = keep;
                half  = 17'(nh);
                dur   = 16'(nd);
            end
            e = (c <= p && h != 0) ? (((c - 1) / h) % 2) : 0;
            chk(tag, $sformatf("sclk_c%0d", c), 32'(sclk_o), 32'(e));
            chk(tag, $sformatf("busy_c%0d", c), 32'(busy_o), 32'd1);
            chk(tag, $sformatf("done_c%0d", c), 32'(done_o), 32'd0);
            chk(tag, $sformatf("ready_c%0d", c), 32'(rdy_o), 32'd0);
        end
        @(negedge clk);
        chk(tag, "done_pulse", 32'(done_o), 32'd1);
        chk(tag, "ready_in_done", 32'(rdy_o), 32'd1);
        chk(tag, "busy_in_done", 32'(busy_o), 32'd0);
        chk(tag, "sclk_in_done", 32'(sclk_o), 32'd0);
        if (!keep) begin
            @(negedge clk);
            chk(tag, "done_falls", 32'(done_o), 32'd0);
            chk(tag, "ready_idle", 32'(rdy_o), 32'd1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sel   = 1'b0;
        valid = 1'b0;
        half  = '0;
        dur   = '0;
        rst_n = 1'b0;

        #1;
        chk("reset", "sclk", 32'(sclk1), 32'd0);
        chk("reset", "busy", 32'(busy1), 32'd0);
        chk("reset", "done", 32'(done1), 32'd0);
        chk("reset", "ready", 32'(rdy1), 32'd1);

        // Release and offer in the same half-cycle: first edge with rst_n high accepts.
        @(negedge clk);
        rst_n = 1'b1;
        play_note(5, 3, 1'b0, 2, 7, "basic");
        play_note(0, 2, 1'b0, 9, 9, "rest");
        play_note(4, 0, 1'b0, 1, 1, "zero_dur");

        // Valid held high: second note taken in the first note's DONE cycle.
        play_note(1, 1, 1'b1, 3, 1, "b2b_first");
        play_note(3, 1, 1'b0, 0, 0, "b2b_second");

        // Reset asynchronously at cycle 12 of an H=5/D=3 note.
        valid = 1'b1;
        half  = 17'd5;
        dur   = 16'd3;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            if (c == 7) chk("mid_rst", "sclk_c7", 32'(sclk1), 32'd1);
        end
        chk("mid_rst", "busy_before", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", "sclk", 32'(sclk1), 32'd0);
        chk("mid_rst", "busy", 32'(busy1), 32'd0);
        chk("mid_rst", "done", 32'(done1), 32'd0);
        chk("mid_rst", "ready", 32'(rdy1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        play_note(2, 1, 1'b0, 0, 0, "post_rst");

        // 4-bit divider at its largest half-period.
        sel = 1'b1;
        play_note(15, 1, 1'b0, 0, 0, "max_d1");
        play_note(15, 4, 1'b0, 0, 0, "max_d4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
